// File: rtl/lcd_pkg.sv
// Shared LCD definitions: byte format, arbiter states, RGB565 colours.
// Imported by the SPI arbiter and the display-side modules.
package lcd_pkg;

  localparam int LCD_BYTE_W = 9;
  localparam int LCD_DC_BIT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    LOCK = 2'd2
  } arb_state_e;

  localparam logic [15:0] RGB565_BLACK = 16'h0000;
  localparam logic [15:0] RGB565_WHITE = 16'hFFFF;
  localparam logic [15:0] RGB565_RED   = 16'hF800;
  localparam logic [15:0] RGB565_GREEN = 16'h07E0;
  localparam logic [15:0] RGB565_BLUE  = 16'h001F;

  function automatic logic [LCD_BYTE_W-1:0] lcd_cmd(
    input logic [7:0] b
  );
    return {1'b0, b};
  endfunction

  function automatic logic [LCD_BYTE_W-1:0] lcd_dat(
    input logic [7:0] b
  );
    return {1'b1, b};
  endfunction

endpackage

// File: rtl/lcd_spi_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Search starts at ptr+1 and wraps; returns onehot grant and index.
module rr_pick #(
  parameter int N  = 3,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 1; k <= N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!any && req[i] &&
            ((int'(ptr) + k) % N) == i) begin
          gnt[i] = 1'b1;
          idx    = IW'(i);
          any    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/lcd_spi_arbiter.sv
// Burst arbiter in front of the lcd_write SPI byte engine.
// Whole bursts are granted; a stalled engine is flagged by timeout.
module lcd_spi_arbiter
  import lcd_pkg::*;
#(
  parameter  int NUM_REQ     = 3,
  parameter  int TIMEOUT_CYC = 1024,
  localparam int IW          = $clog2(NUM_REQ)
) (
  input  logic                    clk_50MHz,
  input  logic                    rst_n,
  input  logic                    init_done,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*9-1:0]    req_data,
  input  logic [NUM_REQ-1:0]      req_last,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [LCD_BYTE_W-1:0]   data,
  output logic                    en_write,
  input  logic                    wr_done,
  output logic [IW-1:0]           grant_id,
  output logic                    busy,
  output logic                    err_timeout,
  input  logic                    err_clr
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  arb_state_e state, state_n;

  logic [IW-1:0]         grant_q;
  logic [IW-1:0]         rr_ptr;
  logic [IW-1:0]         pick_idx;
  logic [NUM_REQ-1:0]    elig;
  logic [NUM_REQ-1:0]    pick_gnt;
  logic                  pick_any;
  logic [LCD_BYTE_W-1:0] byte_a [NUM_REQ];
  logic [LCD_BYTE_W-1:0] sel_byte;
  logic                  sel_last;
  logic [LCD_BYTE_W-1:0] data_q;
  logic                  last_q;
  logic [TW-1:0]         timer;
  logic                  tmo;
  logic                  err_q;
  logic                  accept;

  // Until the panel is initialised only the init sequencer may talk.
  assign elig = init_done
              ? req_valid
              : {{(NUM_REQ-1){1'b0}}, req_valid[0]};

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .req (elig),
    .ptr (rr_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++)
      byte_a[i] = req_data[LCD_BYTE_W*i +: LCD_BYTE_W];
  end

  always_comb begin
    state_n   = state;
    req_ready = '0;
    tmo       = 1'b0;
    if (rst_n) begin
      unique case (state)
        IDLE: begin
          if (pick_any) begin
            req_ready = pick_gnt;
            state_n   = XFER;
          end
        end
        XFER: begin
          if (wr_done)
            state_n = last_q ? IDLE : LOCK;
          else if (timer == TW'(TIMEOUT_CYC - 1)) begin
            tmo     = 1'b1;
            state_n = IDLE;
          end
        end
        LOCK: begin
          for (int i = 0; i < NUM_REQ; i++)
            if (IW'(i) == grant_q && req_valid[i])
              req_ready[i] = 1'b1;
          if (|req_ready)
            state_n = XFER;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign accept = |req_ready;

  always_comb begin
    sel_byte = '0;
    sel_last = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        sel_byte = byte_a[i];
        sel_last = req_last[i];
      end
    end
  end

  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      data_q <= '0;
      last_q <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        data_q <= sel_byte;
        last_q <= sel_last;
      end
    end
  end

  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      grant_q <= '0;
      rr_ptr  <= IW'(NUM_REQ - 1);
    end else if (state == IDLE && pick_any) begin
      grant_q <= pick_idx;
      rr_ptr  <= pick_idx;
    end
  end

  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n)
      timer <= '0;
    else if (state == XFER && !wr_done && !tmo)
      timer <= timer + 1'b1;
    else
      timer <= '0;
  end

  // Setting wins over a simultaneous clear.
  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n)
      err_q <= 1'b0;
    else if (tmo)
      err_q <= 1'b1;
    else if (err_clr)
      err_q <= 1'b0;
  end

  assign data        = data_q;
  assign en_write    = (state == XFER);
  assign busy        = (state != IDLE);
  assign grant_id    = grant_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_lcd_spi_arbiter.sv
// Bench for lcd_spi_arbiter: lcd_write model, byte scoreboard,
// round-robin rule checker and directed plus random bursts.
module tb_lcd_spi_arbiter;

  logic        clk_50MHz = 1'b0;
  logic        rst_n;
  logic        init_done;
  logic        err_clr;
  logic        wr_done = 1'b0;
  logic [2:0]  req_valid;
  logic [26:0] req_data;
  logic [2:0]  req_last;
  logic [2:0]  req_ready;
  logic [8:0]  data;
  logic        en_write;
  logic [1:0]  grant_id;
  logic        busy;
  logic        err_timeout;

  logic       v [3];
  logic [8:0] d [3];
  logic       l [3];

  assign req_valid = {v[2], v[1], v[0]};
  assign req_last  = {l[2], l[1], l[0]};
  assign req_data  = {d[2], d[1], d[0]};

  lcd_spi_arbiter #(
    .NUM_REQ     (3),
    .TIMEOUT_CYC (1024)
  ) dut (
    .clk_50MHz   (clk_50MHz),
    .rst_n       (rst_n),
    .init_done   (init_done),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .data        (data),
    .en_write    (en_write),
    .wr_done     (wr_done),
    .grant_id    (grant_id),
    .busy        (busy),
    .err_timeout (err_timeout),
    .err_clr     (err_clr)
  );

  always #10 clk_50MHz = ~clk_50MHz;

  int total = 0;
  int bad   = 0;

  function automatic void chk(input string nm,
                              input logic [31:0] got,
                              input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               nm, got, exp, $time);
    end
  endfunction

  // lcd_write model: one wr_done pulse 20-40 cycles after en_write rises
  bit withhold = 0;
  int pend = 0;
  bit en_seen = 0;
  always @(negedge clk_50MHz) begin
    if (!rst_n) begin
      wr_done = 1'b0;
      pend = 0;
      en_seen = 0;
    end else begin
      wr_done = 1'b0;
      if (en_write && !en_seen)
        pend = withhold ? 0 : $urandom_range(20, 40);
      en_seen = en_write;
      if (pend > 0) begin
        pend--;
        if (pend == 0) wr_done = 1'b1;
      end
    end
  end

  // scoreboard entries: {last, id, byte}
  logic [11:0] exp_q [$];
  int          owners [$];
  int          last_win = 2;
  bit          en_prev = 0;
  bit          burst_open = 0;
  logic [1:0]  open_id = 0;
  logic [2:0]  m_ev, m_exp;
  logic [11:0] m_e;

  always @(negedge clk_50MHz) begin
    #2;
    if (!rst_n) begin
      last_win = 2;
      en_prev = 0;
      burst_open = 0;
    end else begin
      m_ev = init_done ? req_valid : (req_valid & 3'b001);
      if (!busy) begin
        burst_open = 0;
        m_exp = '0;
        for (int k = 1; k <= 3; k++) begin
          int j;
          j = (last_win + k) % 3;
          if (m_exp == 3'b000 && m_ev[j]) m_exp[j] = 1'b1;
        end
        if (|req_valid || |req_ready)
          chk("idle_pick", req_ready, m_exp);
        if (|req_ready && req_ready == m_exp)
          for (int k = 0; k < 3; k++)
            if (m_exp[k]) last_win = k;
      end else if (en_write) begin
        chk("xfer_ready", req_ready, 0);
      end else begin
        m_exp = req_valid[last_win] ? (3'b001 << last_win) : 3'b000;
        if (|req_valid || |req_ready)
          chk("lock_ready", req_ready, m_exp);
      end
      if (en_write && !en_prev) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected", en_write, 0);
        end else begin
          m_e = exp_q.pop_front();
          chk("sb_data", data, m_e[8:0]);
          chk("sb_owner", grant_id, m_e[10:9]);
          if (burst_open)
            chk("no_interleave", grant_id, open_id);
          else
            owners.push_back(int'(grant_id));
          burst_open = !m_e[11];
          open_id = m_e[10:9];
        end
      end
      en_prev = en_write;
    end
  end

  bit abort_f = 0;

  task automatic drv(input int id, input logic [8:0] b [8],
                     input int n, input int gap_at);
    int t;
    bit got;
    int gb;
    for (int k = 0; k < n; k++) begin
      if (abort_f) break;
      @(negedge clk_50MHz);
      v[id] = 1'b1;
      d[id] = b[k];
      l[id] = (k == n - 1);
      got = 0;
      t = 0;
      while (!got && !abort_f && t < 4000) begin
        #1;
        if (req_ready[id] === 1'b1) begin
          got = 1;
          exp_q.push_back({l[id], 2'(id), b[k]});
        end else begin
          t++;
          @(negedge clk_50MHz);
        end
      end
      if (!got) begin
        if (!abort_f) chk("accept", got, 1);
        break;
      end
      if (k == gap_at) begin
        @(negedge clk_50MHz);
        v[id] = 1'b0;
        t = 0;
        while (!(busy && !en_write) && t < 200) begin
          @(negedge clk_50MHz);
          #1;
          t++;
        end
        chk("lock_entered", busy && !en_write, 1);
        gb = 0;
        repeat (50) begin
          @(negedge clk_50MHz);
          #1;
          if (en_write || |req_ready) gb++;
        end
        chk("lock_hold", gb, 0);
      end
    end
    if (!abort_f) @(negedge clk_50MHz);
    v[id] = 1'b0;
    l[id] = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((busy || exp_q.size() != 0) && t < 6000) begin
      @(negedge clk_50MHz);
      #1;
      t++;
    end
    chk("idle_reached", busy, 0);
  endtask

  logic [8:0] b1 [8];
  logic [8:0] b3 [8];
  logic [8:0] pix [8];
  logic [8:0] rb [3][8];
  int         rn [3];
  int         rd [3];
  int         cnt, t;

  initial begin
    #2ms;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    b1  = '{9'h011, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0};
    b3  = '{9'h02A, 9'h100, 9'h1EF, 9'h0,
            9'h0, 9'h0, 9'h0, 9'h0};
    pix = '{9'h1F8, 9'h100, 9'h1F8, 9'h100,
            9'h1F8, 9'h100, 9'h1F8, 9'h100};
    rst_n = 1'b0;
    init_done = 1'b0;
    err_clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      v[i] = 1'b0;
      d[i] = 9'h0;
      l[i] = 1'b0;
    end
    v[0] = 1'b1;
    v[1] = 1'b1;
    repeat (3) @(negedge clk_50MHz);
    #1;
    chk("rst_en_write", en_write, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_data", data, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_ready", req_ready, 0);
    @(negedge clk_50MHz);
    v[0] = 1'b0;
    v[1] = 1'b0;
    rst_n = 1'b1;

    // 1: gating before init_done
    @(negedge clk_50MHz);
    v[1] = 1'b1; d[1] = 9'h055;
    v[2] = 1'b1; d[2] = 9'h066;
    cnt = 0;
    repeat (10) begin
      @(negedge clk_50MHz);
      #1;
      if (en_write || |req_ready) cnt++;
    end
    chk("gate_no_grant", cnt, 0);
    owners.delete();
    drv(0, b1, 1, -1);
    wait_idle();
    chk("t1_grant", grant_id, 0);
    chk("t1_data", data, 9'h011);
    chk("t1_bursts", owners.size(), 1);
    @(negedge clk_50MHz);
    v[1] = 1'b0;
    v[2] = 1'b0;

    // 2: two 3-byte bursts, then round-robin second round
    init_done = 1'b1;
    owners.delete();
    fork
      drv(1, b3, 3, -1);
      drv(2, b3, 3, -1);
    join
    wait_idle();
    chk("t2_n", owners.size(), 2);
    chk("t2_first", owners[0], 1);
    chk("t2_second", owners[1], 2);
    owners.delete();
    fork
      drv(2, b3, 3, -1);
      begin
        repeat (3) @(negedge clk_50MHz);
        drv(1, b3, 3, -1);
      end
    join
    wait_idle();
    chk("t2b_n", owners.size(), 2);
    chk("t2b_first", owners[0], 2);
    chk("t2b_second", owners[1], 1);

    // 3: pixel stream must not be split
    owners.delete();
    fork
      drv(2, pix, 8, -1);
      begin
        repeat (5) @(negedge clk_50MHz);
        drv(1, b1, 1, -1);
      end
    join
    wait_idle();
    chk("t3_n", owners.size(), 2);
    chk("t3_first", owners[0], 2);
    chk("t3_second", owners[1], 1);

    // 4: owner stalls in LOCK while another requests
    owners.delete();
    fork
      drv(2, b3, 3, 0);
      begin
        repeat (5) @(negedge clk_50MHz);
        drv(1, b3, 2, -1);
      end
    join
    wait_idle();
    chk("t4_n", owners.size(), 2);
    chk("t4_first", owners[0], 2);

    // 5: engine never answers
    withhold = 1;
    fork
      drv(0, b1, 1, -1);
      begin
        t = 0;
        while (!en_write && t < 500) begin
          @(negedge clk_50MHz);
          #1;
          t++;
        end
        cnt = 0;
        while (en_write && cnt < 3000) begin
          cnt++;
          @(negedge clk_50MHz);
          #1;
        end
      end
    join
    chk("timeout_len", cnt, 1024);
    chk("timeout_err", err_timeout, 1);
    chk("timeout_idle", busy, 0);
    withhold = 0;
    @(negedge clk_50MHz);
    err_clr = 1'b1;
    @(negedge clk_50MHz);
    err_clr = 1'b0;
    #1;
    chk("err_cleared", err_timeout, 0);

    // 6: reset in the middle of a transfer
    fork
      drv(1, b3, 3, -1);
    join_none
    t = 0;
    while (!en_write && t < 500) begin
      @(negedge clk_50MHz);
      #1;
      t++;
    end
    repeat (5) @(negedge clk_50MHz);
    v[0] = 1'b1;
    #3;
    rst_n = 1'b0;
    abort_f = 1;
    #1;
    chk("mid_rst_en", en_write, 0);
    chk("mid_rst_ready", req_ready, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_err", err_timeout, 0);
    exp_q.delete();
    repeat (3) @(negedge clk_50MHz);
    for (int i = 0; i < 3; i++) v[i] = 1'b0;
    exp_q.delete();
    owners.delete();
    abort_f = 0;
    init_done = 1'b0;
    rst_n = 1'b1;
    @(negedge clk_50MHz);
    v[1] = 1'b1;
    d[1] = 9'h0C3;
    drv(0, b1, 1, -1);
    wait_idle();
    chk("post_rst_n", owners.size(), 1);
    chk("post_rst_owner", owners[0], 0);
    v[1] = 1'b0;

    // random bursts from all requesters
    init_done = 1'b1;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 3; i++) begin
        rn[i] = $urandom_range(1, 8);
        rd[i] = $urandom_range(0, 60);
        for (int k = 0; k < 8; k++)
          rb[i][k] = 9'($urandom);
      end
      fork
        begin
          repeat (rd[0]) @(negedge clk_50MHz);
          drv(0, rb[0], rn[0], -1);
        end
        begin
          repeat (rd[1]) @(negedge clk_50MHz);
          drv(1, rb[1], rn[1], -1);
        end
        begin
          repeat (rd[2]) @(negedge clk_50MHz);
          drv(2, rb[2], rn[2], -1);
        end
      join
      wait_idle();
    end
    chk("sb_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
